// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial deframer: FSM state encoding,
// default payload width and the even-parity reduction.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  // Widest payload the parity helper accepts; narrower words are zero-extended.
  localparam int PARITY_MAX_W = 64;

  // Even parity of a word: 1 when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/deframe_fifo.sv
// Two-entry first-in first-out buffer with a registered head.
// The head register drives dout/valid directly; a second register holds the
// next word. A push into a full buffer is dropped unless a pop frees a slot
// in the same cycle, in which case the push is accepted.
module deframe_fifo
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             ovf
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic             head_vld_r;
  logic             tail_vld_r;
  logic             ovf_r;

  logic [WIDTH-1:0] head_next_s;
  logic [WIDTH-1:0] tail_next_s;
  logic             head_vld_next_s;
  logic             tail_vld_next_s;
  logic             ovf_next_s;
  logic             pop_s;

  // Next-state of the two slots from push/pop and current occupancy.
  always_comb begin
    head_next_s     = head_r;
    tail_next_s     = tail_r;
    head_vld_next_s = head_vld_r;
    tail_vld_next_s = tail_vld_r;
    ovf_next_s      = 1'b0;
    pop_s           = head_vld_r & ready;

    case ({head_vld_r, tail_vld_r})
      2'b00: begin
        // Empty: a pop request is meaningless, no bypass to the output.
        if (push) begin
          head_next_s     = din;
          head_vld_next_s = 1'b1;
        end else begin
          head_vld_next_s = 1'b0;
        end
      end
      2'b10: begin
        if (push && pop_s) begin
          head_next_s = din;
        end else if (pop_s) begin
          head_vld_next_s = 1'b0;
        end else if (push) begin
          tail_next_s     = din;
          tail_vld_next_s = 1'b1;
        end else begin
          head_vld_next_s = 1'b1;
        end
      end
      2'b11: begin
        if (push && pop_s) begin
          head_next_s = tail_r;
          tail_next_s = din;
        end else if (pop_s) begin
          head_next_s     = tail_r;
          tail_vld_next_s = 1'b0;
        end else if (push) begin
          // Full with no pop: the incoming word is lost, contents untouched.
          ovf_next_s = 1'b1;
        end else begin
          tail_vld_next_s = 1'b1;
        end
      end
      default: begin
        // Tail valid without head is unreachable; recover to empty.
        head_vld_next_s = 1'b0;
        tail_vld_next_s = 1'b0;
      end
    endcase
  end

  // Slot registers and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r     <= '0;
      tail_r     <= '0;
      head_vld_r <= 1'b0;
      tail_vld_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      head_r     <= head_next_s;
      tail_r     <= tail_next_s;
      head_vld_r <= head_vld_next_s;
      tail_vld_r <= tail_vld_next_s;
      ovf_r      <= ovf_next_s;
    end
  end

  assign dout  = head_r;
  assign valid = head_vld_r;
  assign ovf   = ovf_r;

endmodule

// File: rtl/serial_deframer.sv
// Serial deframer: recognises start / payload (LSB first) / optional even
// parity / stop frames on si, assembles the payload and queues
// {parity error, payload} in a two-entry output buffer.
module serial_deframer
  import serial_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  output logic [DATA_W-1:0] dout,
  output logic              dout_perr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              ovf,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_next_s;
  logic [DATA_W-1:0]       payload_r;
  logic [DATA_W-1:0]       payload_next_s;
  logic                    perr_r;
  logic                    perr_next_s;
  logic                    frame_err_r;
  logic                    ferr_next_s;
  logic                    busy_r;
  logic                    push_s;
  logic [PARITY_MAX_W-1:0] par_ext_s;
  logic [DATA_W:0]         fifo_dout_s;

  // Frame FSM next-state, bit counter, payload assembly and push/error strobes.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    payload_next_s = payload_r;
    perr_next_s    = perr_r;
    push_s         = 1'b0;
    ferr_next_s    = 1'b0;
    par_ext_s      = '0;
    par_ext_s[DATA_W-1:0] = payload_r;

    case (state_r)
      ST_IDLE: begin
        if (si) begin
          state_next_s = ST_DATA;
          cnt_next_s   = '0;
          perr_next_s  = 1'b0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        payload_next_s[cnt_r] = si;
        if (cnt_r == CNT_W'(DATA_W - 1)) begin
          cnt_next_s   = '0;
          state_next_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end else begin
          cnt_next_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        // Mismatch when payload ones plus the parity bit are odd.
        perr_next_s  = even_parity(par_ext_s) ^ si;
        state_next_s = ST_STOP;
      end
      ST_STOP: begin
        // A 1 here is a framing error, never a start bit for the next frame.
        if (!si) begin
          push_s = 1'b1;
        end else begin
          ferr_next_s = 1'b1;
        end
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Frame state, counter, payload and status pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      payload_r   <= '0;
      perr_r      <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      payload_r   <= payload_next_s;
      perr_r      <= perr_next_s;
      frame_err_r <= ferr_next_s;
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  deframe_fifo #(
    .WIDTH(DATA_W + 1)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .din  ({perr_r, payload_r}),
    .ready(dout_ready),
    .dout (fifo_dout_s),
    .valid(dout_valid),
    .ovf  (ovf)
  );

  assign dout      = fifo_dout_s[DATA_W-1:0];
  assign dout_perr = fifo_dout_s[DATA_W];
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_serial_deframer.sv
// Self-checking bench for serial_deframer (DATA_W=8, PARITY_EN=1).
// Reference model: a queue of stored words, capacity 2, updated once per
// clock from what the bench knows it has sent (frame boundaries, parity rule).
module tb_serial_deframer;

  logic       clk = 1'b0;
  logic       rst;
  logic       si;
  logic [7:0] dout;
  logic       dout_perr;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_err;
  logic       ovf;
  logic       busy;

  int nvec = 0;
  int nfail = 0;

  logic [8:0] q[$];

  always #5 clk = ~clk;

  serial_deframer #(.DATA_W(8), .PARITY_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .si        (si),
    .dout      (dout),
    .dout_perr (dout_perr),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .frame_err (frame_err),
    .ovf       (ovf),
    .busy      (busy)
  );

  function automatic logic pick(input int sel);
    if (sel == 0) return 1'b0;
    else if (sel == 1) return 1'b1;
    else return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive si/ready, advance the model, compare all outputs.
  task automatic step(input logic b, input logic rdy, input logic push_evt,
                      input logic ferr_evt, input logic [8:0] word, input logic exp_busy);
    logic exp_ovf;
    si = b;
    dout_ready = rdy;
    @(posedge clk);
    exp_ovf = 1'b0;
    if (rdy && q.size() > 0) q.delete(0);
    if (push_evt) begin
      if (q.size() < 2) q.push_back(word);
      else exp_ovf = 1'b1;
    end
    #1;
    nvec++;
    if (dout_valid !== (q.size() > 0)) begin
      nfail++;
      $display("FAIL valid: got %b want %b (t=%0t)", dout_valid, q.size() > 0, $time);
    end
    if (q.size() > 0) begin
      nvec++;
      if ({dout_perr, dout} !== q[0]) begin
        nfail++;
        $display("FAIL head_word: got perr=%b dout=%h want perr=%b dout=%h (t=%0t)",
                 dout_perr, dout, q[0][8], q[0][7:0], $time);
      end
    end
    nvec++;
    if (ovf !== exp_ovf) begin
      nfail++;
      $display("FAIL ovf: got %b want %b (t=%0t)", ovf, exp_ovf, $time);
    end
    nvec++;
    if (frame_err !== ferr_evt) begin
      nfail++;
      $display("FAIL frame_err: got %b want %b (t=%0t)", frame_err, ferr_evt, $time);
    end
    nvec++;
    if (busy !== exp_busy) begin
      nfail++;
      $display("FAIL busy: got %b want %b (t=%0t)", busy, exp_busy, $time);
    end
  endtask

  // Full frame; par_flip inverts the correct even-parity bit.
  task automatic send_frame(input logic [7:0] pl, input logic par_flip, input logic stop,
                            input int rdy_body, input int rdy_stop);
    logic       pb;
    logic [8:0] w;
    pb = (^pl) ^ par_flip;
    w  = {(^pl) ^ pb, pl};
    step(1'b1, pick(rdy_body), 1'b0, 1'b0, w, 1'b1);
    for (int i = 0; i < 8; i++) step(pl[i], pick(rdy_body), 1'b0, 1'b0, w, 1'b1);
    step(pb, pick(rdy_body), 1'b0, 1'b0, w, 1'b1);
    step(stop, pick(rdy_stop), ~stop, stop, w, 1'b0);
  endtask

  task automatic idle(input int n, input int rdy_sel);
    for (int i = 0; i < n; i++) step(1'b0, pick(rdy_sel), 1'b0, 1'b0, 9'h000, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && q.size() > 0; i++) idle(1, 1);
    idle(1, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    si = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    q.delete();
    #1;
    nvec++;
    if ({dout, dout_perr, dout_valid, frame_err, ovf, busy} !== 13'h0) begin
      nfail++;
      $display("FAIL reset_outputs: got dout=%h perr=%b valid=%b ferr=%b ovf=%b busy=%b want all 0",
               dout, dout_perr, dout_valid, frame_err, ovf, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    idle(2, 0);
    send_frame(8'hA5, 1'b0, 1'b0, 0, 0);
    nvec++;
    if (dout_valid !== 1'b1 || dout !== 8'hA5 || dout_perr !== 1'b0) begin
      nfail++;
      $display("FAIL single_frame: got valid=%b dout=%h perr=%b want 1 a5 0", dout_valid, dout, dout_perr);
    end
    idle(2, 0);
    nvec++;
    if (dout !== 8'hA5) begin
      nfail++;
      $display("FAIL hold_stable: got %h want a5", dout);
    end
    drain();
  endtask

  task automatic test_parity_error();
    send_frame(8'hA5, 1'b1, 1'b0, 0, 0);
    nvec++;
    if (dout !== 8'hA5 || dout_perr !== 1'b1 || frame_err !== 1'b0) begin
      nfail++;
      $display("FAIL parity_error: got dout=%h perr=%b ferr=%b want a5 1 0", dout, dout_perr, frame_err);
    end
    drain();
  endtask

  task automatic test_bad_stop();
    send_frame(8'h3C, 1'b0, 1'b1, 0, 0);
    nvec++;
    if (frame_err !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL bad_stop: got ferr=%b valid=%b busy=%b want 1 0 0", frame_err, dout_valid, busy);
    end
    idle(1, 0);
    send_frame(8'h66, 1'b0, 1'b0, 0, 0);
    drain();
  endtask

  task automatic test_overflow();
    send_frame(8'h01, 1'b0, 1'b0, 0, 0);
    send_frame(8'h02, 1'b0, 1'b0, 0, 0);
    send_frame(8'h03, 1'b0, 1'b0, 0, 0);
    nvec++;
    if (ovf !== 1'b1 || dout !== 8'h01) begin
      nfail++;
      $display("FAIL overflow: got ovf=%b dout=%h want 1 01", ovf, dout);
    end
    idle(1, 1);
    nvec++;
    if (dout !== 8'h02 || dout_valid !== 1'b1) begin
      nfail++;
      $display("FAIL drain_second: got valid=%b dout=%h want 1 02", dout_valid, dout);
    end
    idle(1, 1);
    nvec++;
    if (dout_valid !== 1'b0) begin
      nfail++;
      $display("FAIL drain_empty: got valid=%b want 0", dout_valid);
    end
  endtask

  task automatic test_full_pop();
    send_frame(8'h01, 1'b0, 1'b0, 0, 0);
    send_frame(8'h02, 1'b0, 1'b0, 0, 0);
    send_frame(8'h04, 1'b0, 1'b0, 0, 1);
    nvec++;
    if (ovf !== 1'b0 || dout !== 8'h02) begin
      nfail++;
      $display("FAIL full_pop: got ovf=%b dout=%h want 0 02", ovf, dout);
    end
    idle(1, 1);
    nvec++;
    if (dout !== 8'h04 || dout_valid !== 1'b1) begin
      nfail++;
      $display("FAIL full_pop_last: got valid=%b dout=%h want 1 04", dout_valid, dout);
    end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] w;
    w = 9'h000;
    step(1'b1, 1'b0, 1'b0, 1'b0, w, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, w, 1'b1);
    test_reset();
    nvec++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL busy_after_reset: got %b want 0", busy);
    end
    send_frame(8'h5A, 1'b0, 1'b0, 0, 0);
    nvec++;
    if (dout !== 8'h5A || dout_perr !== 1'b0) begin
      nfail++;
      $display("FAIL after_reset_frame: got dout=%h perr=%b want 5a 0", dout, dout_perr);
    end
    idle(1, 1);
    nvec++;
    if (dout_valid !== 1'b0) begin
      nfail++;
      $display("FAIL after_reset_residue: got valid=%b want 0", dout_valid);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 60; n++) begin
      send_frame(8'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), 2, 2);
      idle($urandom_range(0, 2), 2);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    si = 1'b0;
    dout_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_parity_error();
    test_bad_stop();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/serial_deframer.md
SERIAL_DEFRAMER -- requirements
Module: serial_deframer

Interface
REQ-001 Parameter DATA_W, default 8: number of payload bits per frame.
REQ-002 Parameter PARITY_EN, default 1: 1 means an even-parity bit follows the payload; 0 means there is no parity bit.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 si  input  1  serial line from the upstream shift-register stage; idle level 0; sampled once per clk.
REQ-006 dout  output  DATA_W  assembled payload word at the FIFO head.
REQ-007 dout_perr  output  1  parity-error flag travelling with dout (1 = parity mismatch).
REQ-008 dout_valid  output  1  FIFO head holds a word.
REQ-009 dout_ready  input  1  consumer accepts the head word when dout_valid & dout_ready.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled as 1.
REQ-011 ovf  output  1  one-cycle pulse: completed word dropped because the FIFO was full.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Frame format: start bit 1, then DATA_W payload bits LSB first, then the parity bit if PARITY_EN=1, then stop bit 0.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: si=1 moves the FSM to DATA and clears the bit counter; si=0 keeps it in IDLE.
REQ-016 DATA: each cycle stores si into bit[cnt] and increments cnt.
REQ-017 DATA exit: after DATA_W samples, the FSM moves to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-018 PARITY: samples si as the parity bit and moves to STOP; perr = (XOR of payload) XOR parity bit; perr = 0 when PARITY_EN=0.
REQ-019 STOP with si=0: the word {perr, payload} is pushed into the FIFO and the FSM returns to IDLE.
REQ-020 STOP with si=1: the word is discarded, frame_err pulses on the next cycle, and the FSM returns to IDLE; that 1 is not treated as a start bit.
REQ-021 A new start bit is accepted in the cycle immediately after STOP, so back-to-back frames are supported.
REQ-022 The FIFO is 2 entries deep and first-in first-out; dout, dout_perr and dout_valid are registered.
REQ-023 Latency: a word pushed on a stop-sample edge appears on dout with dout_valid=1 from the following cycle when the FIFO was empty.
REQ-024 dout and dout_perr hold stable while dout_valid=1 and dout_ready=0.
REQ-025 Push and pop in the same cycle with the FIFO full: the pop frees a slot, the push is accepted, and ovf stays 0.
REQ-026 Push with the FIFO full and no pop: the new word is dropped, ovf pulses for 1 cycle, and the stored contents are unchanged.
REQ-027 Push and pop in the same cycle with the FIFO empty: no bypass; the pop is ignored because dout_valid=0.
REQ-028 A parity error does not block storage: the word is stored with dout_perr=1.

Reset
REQ-029 When rst=1 at a clk edge: FSM goes to IDLE, cnt=0, payload register=0, FIFO is emptied.
REQ-030 When rst=1 at a clk edge: dout=0, dout_perr=0, dout_valid=0, frame_err=0, ovf=0, busy=0.
REQ-031 rst asserted mid-frame abandons the partial word, produces no error pulse, and leaves no residue in later frames.

Structure
REQ-032 A shared package serial_pkg holds the FSM state enum, the default DATA_W and an even-parity function.
REQ-033 The 2-entry FIFO is a sub-module deframe_fifo with parameter WIDTH = DATA_W+1.
REQ-034 The FSM, counter and payload assembly sit in serial_deframer.

Verification
REQ-035 Bench scenario, single frame: DATA_W=8, PARITY_EN=1, serial bits 1,1,0,1,0,0,1,0,1,0,0 -> dout=0xA5, dout_perr=0, dout_valid rises 1 cycle after the stop sample.
REQ-036 Bench scenario, parity error: the same frame with the parity bit 1 -> dout=0xA5, dout_perr=1, frame_err=0.
REQ-037 Bench scenario, bad stop bit: frame 0x3C with stop bit 1 -> frame_err pulses 1 cycle, no push, FSM back in IDLE.
REQ-038 Bench scenario, overflow: three back-to-back frames 0x01, 0x02, 0x03 with dout_ready=0 -> FIFO holds 0x01, 0x02; ovf pulses on the third; raising dout_ready drains 0x01 then 0x02.
REQ-039 Bench scenario, full FIFO with simultaneous pop: FIFO full, dout_ready=1 on the stop-sample cycle of 0x04 -> ovf=0; output order 0x01, 0x02, 0x04.
REQ-040 Bench scenario, reset mid-frame: rst pulsed after 4 payload bits, then a clean frame 0x5A -> only 0x5A is output, busy=0 right after reset.
